r_inst_loader: RTL and testbench

Front-panel instruction loader for the single-cycle R-type CPU: the write side of the CPU's instruction-memory fetch path. It assembles 32-bit instructions from 8-bit switch bytes strobed by a button and writes them sequentially into instruction memory. While loading, it holds the CPU in reset and shows load progress on the 8 LEDs through a 3-bit display select. It sits beside the CPU in the board-level top and owns the instruction-memory write port.

---
 rtl/r_loader_pkg.sv | 24 ++
 rtl/r_inst_loader_edge_pulse.sv | 19 +
 rtl/r_inst_loader.sv | 160 ++++++++++++++++
 tb/tb_r_inst_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/r_loader_pkg.sv
// Shared types and constants for the front-panel instruction loader:
// FSM state encoding, LED display selects and word geometry.
package r_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_FULL    = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [2:0] MUX_ADDR = 3'd0;
   localparam logic [2:0] MUX_STAT = 3'd1;
   localparam logic [2:0] MUX_LW0  = 3'd2;
   localparam logic [2:0] MUX_LW1  = 3'd3;
   localparam logic [2:0] MUX_LW2  = 3'd4;
   localparam logic [2:0] MUX_LW3  = 3'd5;
   localparam logic [2:0] MUX_WCNT = 3'd6;
   localparam logic [2:0] MUX_CSUM = 3'd7;

endpackage

// File: rtl/r_inst_loader_edge_pulse.sv
// Rising-edge detector for a debounced, synchronized button level:
// one-cycle pulse when the level is high now and was low last cycle.
module edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic level_p0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) level_p0 <= 1'b0;
      else      level_p0 <= level;
   end

   assign pulse = level & ~level_p0;

endmodule

// File: rtl/r_inst_loader.sv
// Front-panel instruction loader: builds 32-bit words from switch bytes and
// writes them to instruction memory. Optional checksum: R_LOADER_CHECKSUM_EN.
module r_inst_loader
   import r_loader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        sw,
   input  logic              btn_next,
   input  logic              btn_done,
   input  logic [2:0]        MUX,
   output logic [7:0]        LED,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_hold
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t              state, state_nxt;
   logic                next_e, done_e;
   logic [1:0]          byte_cnt;
   logic [DATA_W-1:0]   word;
   logic [DATA_W-1:0]   last_word;
   logic [ADDR_W-1:0]   addr;
   logic [7:0]          word_cnt;
   logic [7:0]          addr8;
   logic [7:0]          led_nxt;
   logic                capture;
   logic                at_max;
`ifdef R_LOADER_CHECKSUM_EN
   logic [7:0]          csum;
`endif

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < BYTES_PER_WORD; i++) acc = acc ^ w[i*8 +: 8];
      return acc;
   endfunction

   edge_pulse u_next (.clk(clk), .rst(rst), .level(btn_next), .pulse(next_e));
   edge_pulse u_done (.clk(clk), .rst(rst), .level(btn_done), .pulse(done_e));

   // A done edge always wins over a simultaneous next edge.
   assign capture = next_e & ~done_e & ((state == ST_IDLE) | (state == ST_COLLECT));
   assign at_max  = (addr == ADDR_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (done_e)      state_nxt = ST_RUN;
            else if (next_e) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (done_e) state_nxt = ST_RUN;
            else if (next_e && byte_cnt == 2'(BYTES_PER_WORD - 1)) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (done_e)      state_nxt = ST_RUN;
            else if (at_max) state_nxt = ST_FULL;
            else             state_nxt = ST_IDLE;
         end
         ST_FULL: if (done_e) state_nxt = ST_RUN;
         ST_RUN:  if (done_e) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      im_we    = (state == ST_WRITE);
      cpu_hold = (state != ST_RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt  <= 2'd0;
         word      <= '0;
         last_word <= '0;
         addr      <= '0;
         word_cnt  <= 8'd0;
`ifdef R_LOADER_CHECKSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         if (capture) begin
            word[(BYTES_PER_WORD - 1 - int'(byte_cnt))*8 +: 8] <= sw;
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == ST_WRITE) begin
            last_word <= word;
            word_cnt  <= sat_inc8(word_cnt);
            byte_cnt  <= 2'd0;
            if (!at_max) addr <= addr + 1'b1;
`ifdef R_LOADER_CHECKSUM_EN
            csum      <= csum ^ xor_bytes(word);
`endif
         end
         if (state == ST_RUN && done_e) begin
            addr     <= '0;
            word_cnt <= 8'd0;
            byte_cnt <= 2'd0;
`ifdef R_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
         end
      end
   end

   generate
      if (ADDR_W >= 8) begin : g_addr_trunc
         assign addr8 = addr[7:0];
      end else begin : g_addr_ext
         assign addr8 = {{(8 - ADDR_W){1'b0}}, addr};
      end
   endgenerate

   always_comb begin
      led_nxt = 8'h00;
      case (MUX)
         MUX_ADDR: led_nxt = addr8;
         MUX_STAT: led_nxt = {3'(state), 3'b000, byte_cnt};
         MUX_LW0:  led_nxt = last_word[7:0];
         MUX_LW1:  led_nxt = last_word[15:8];
         MUX_LW2:  led_nxt = last_word[23:16];
         MUX_LW3:  led_nxt = last_word[31:24];
         MUX_WCNT: led_nxt = word_cnt;
`ifdef R_LOADER_CHECKSUM_EN
         MUX_CSUM: led_nxt = csum;
`else
         MUX_CSUM: led_nxt = 8'h00;
`endif
         default:  led_nxt = 8'h00;
      endcase
   end

   // LED display is registered, one cycle behind MUX and state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) LED <= 8'h00;
      else      LED <= led_nxt;
   end

   assign im_addr  = addr;
   assign im_wdata = word;

endmodule

// File: tb/tb_r_inst_loader.sv
// Directed self-checking bench for r_inst_loader with a 4-word memory.
module tb_r_inst_loader;

   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        sw;
   logic              btn_next;
   logic              btn_done;
   logic [2:0]        MUX;
   logic [7:0]        LED;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;

   int checks   = 0;
   int failures = 0;

   r_inst_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_done(btn_done),
      .MUX(MUX), .LED(LED), .im_we(im_we), .im_addr(im_addr),
      .im_wdata(im_wdata), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press_next(input logic [7:0] b);
      sw = b; btn_next = 1'b1; step();
      btn_next = 1'b0; step();
   endtask

   task automatic press_next_ignored(input logic [7:0] b, input string tag);
      sw = b; btn_next = 1'b1; step();
      check({tag, "_we_hi"}, 32'(im_we), 32'd0);
      btn_next = 1'b0; step();
      check({tag, "_we_lo"}, 32'(im_we), 32'd0);
   endtask

   task automatic press_done(input logic exp_hold, input string tag);
      btn_done = 1'b1; step();
      check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
      check({tag, "_we"}, 32'(im_we), 32'd0);
      btn_done = 1'b0; step();
   endtask

   task automatic write_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input string tag);
      press_next(w[31:24]);
      press_next(w[23:16]);
      press_next(w[15:8]);
      sw = w[7:0]; btn_next = 1'b1; step();
      check({tag, "_we"}, 32'(im_we), 32'd1);
      check({tag, "_addr"}, 32'(im_addr), 32'(a));
      check({tag, "_data"}, im_wdata, w);
      btn_next = 1'b0; step();
      check({tag, "_we_end"}, 32'(im_we), 32'd0);
   endtask

   task automatic led_check(input logic [2:0] sel, input logic [7:0] exp, input string tag);
      MUX = sel; step();
      check(tag, 32'(LED), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; sw = 8'h00; btn_next = 1'b0; btn_done = 1'b0; MUX = 3'd0;
      step(); step();
      check("rst_led", 32'(LED), 32'd0);
      check("rst_we", 32'(im_we), 32'd0);
      check("rst_addr", 32'(im_addr), 32'd0);
      check("rst_wdata", im_wdata, 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      rst = 1'b1; step();
      led_check(3'd1, 8'h00, "idle_stat");

      // First word and LED views of it
      write_word(32'h00222020, 2'd0, "w0");
      check("w0_addr_after", 32'(im_addr), 32'd1);
      led_check(3'd5, 8'h00, "lw3");
      led_check(3'd4, 8'h22, "lw2");
      led_check(3'd3, 8'h20, "lw1");
      led_check(3'd2, 8'h20, "lw0");
      led_check(3'd6, 8'h01, "wcnt1");
      led_check(3'd0, 8'h01, "led_addr1");
      led_check(3'd1, 8'h00, "stat_idle2");

      // Fill memory, then FULL ignores further bytes
      write_word(32'h11111111, 2'd1, "w1");
      write_word(32'h22222222, 2'd2, "w2");
      write_word(32'h33333333, 2'd3, "w3");
      check("full_addr", 32'(im_addr), 32'd3);
      led_check(3'd1, 8'h60, "full_stat");
      led_check(3'd6, 8'h04, "wcnt4");
      led_check(3'd2, 8'h33, "lw0_w3");
      press_next_ignored(8'hAA, "full_n0");
      press_next_ignored(8'hBB, "full_n1");
      press_next_ignored(8'hCC, "full_n2");
      press_next_ignored(8'hDD, "full_n3");
      check("full_addr_hold", 32'(im_addr), 32'd3);
      led_check(3'd1, 8'h60, "full_stat2");
      led_check(3'd2, 8'h33, "full_lw0_hold");
      press_done(1'b0, "full_done");
      led_check(3'd1, 8'h80, "run_stat");

      // Reload from RUN
      press_done(1'b1, "reload1");
      check("reload_addr", 32'(im_addr), 32'd0);
      led_check(3'd6, 8'h00, "reload_wcnt");
      led_check(3'd1, 8'h00, "reload_stat");

      // Partial word discarded by done
      press_next(8'h12);
      press_next(8'h34);
      led_check(3'd1, 8'h22, "coll2_stat");
      press_done(1'b0, "partial_done");
      led_check(3'd1, 8'h82, "run_partial_stat");
      press_next_ignored(8'h56, "run_n0");
      press_next_ignored(8'h78, "run_n1");
      check("run_addr", 32'(im_addr), 32'd0);
      led_check(3'd1, 8'h82, "run_stat_hold");
      led_check(3'd6, 8'h00, "run_wcnt");

      // Simultaneous next and done in COLLECT
      press_done(1'b1, "reload2");
      MUX = 3'd1;
      press_next(8'hAB);
      led_check(3'd1, 8'h21, "coll1_stat");
      sw = 8'h55; btn_next = 1'b1; btn_done = 1'b1; step();
      check("simul_hold", 32'(cpu_hold), 32'd0);
      check("simul_we", 32'(im_we), 32'd0);
      btn_next = 1'b0; btn_done = 1'b0; step();
      led_check(3'd1, 8'h81, "simul_stat");

      // Reset during COLLECT after 3 bytes
      press_done(1'b1, "reload3");
      write_word(32'hDEADBEEF, 2'd0, "wd");
      check("wd_addr_after", 32'(im_addr), 32'd1);
      press_next(8'h01);
      press_next(8'h02);
      press_next(8'h03);
      led_check(3'd1, 8'h23, "coll3_stat");
      rst = 1'b0; #1;
      check("mid_rst_we", 32'(im_we), 32'd0);
      check("mid_rst_hold", 32'(cpu_hold), 32'd1);
      check("mid_rst_addr", 32'(im_addr), 32'd0);
      check("mid_rst_wdata", im_wdata, 32'd0);
      check("mid_rst_led", 32'(LED), 32'd0);
      step();
      rst = 1'b1; step();
      write_word(32'h01020304, 2'd0, "wc");
`ifdef R_LOADER_CHECKSUM_EN
      led_check(3'd7, 8'h04, "csum");
`else
      led_check(3'd7, 8'h00, "csum");
`endif
      led_check(3'd0, 8'h01, "wc_led_addr");
      led_check(3'd6, 8'h01, "wc_wcnt");

      // Reset during WRITE drops im_we at once
      press_next(8'hA1);
      press_next(8'hA2);
      press_next(8'hA3);
      sw = 8'hA4; btn_next = 1'b1; step();
      check("wr_rst_we_before", 32'(im_we), 32'd1);
      check("wr_rst_addr_before", 32'(im_addr), 32'd1);
      rst = 1'b0; #1;
      check("wr_rst_we", 32'(im_we), 32'd0);
      check("wr_rst_addr", 32'(im_addr), 32'd0);
      btn_next = 1'b0; step();
      rst = 1'b1; step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
